// File: rtl/jcapture_ctrl.sv
// jcapture_ctrl: pixel-clock capture sequencer that gates the ISP to whole
// frames, waits for encode_done and reports image_valid.
// Ports: clk, resetn (async low); start_capture, abort, continuous,
//   skip_frames, timeout_cycles, frame_valid, encode_done in;
//   jpeg_en, image_valid, busy, timeout_err, frame_cnt, state out.
// Build option: define JCAPTURE_TIMEOUT_EN to add the COMPRESS watchdog,
//   the sticky timeout_err flag and the ERROR state.
module jcapture_ctrl #(
  parameter int TIMEOUT_W   = 24,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start_capture,
  input  logic                   abort,
  input  logic                   continuous,
  input  logic [3:0]             skip_frames,
  input  logic [TIMEOUT_W-1:0]   timeout_cycles,
  input  logic                   frame_valid,
  input  logic                   encode_done,
  output logic                   jpeg_en,
  output logic                   image_valid,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [2:0]             state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_WAIT    = 3'd2,
    S_COMP    = 3'd3,
    S_VALID   = 3'd4,
    S_ERROR   = 3'd5
  } st_e;

  st_e                  state_q, state_d;
  logic [3:0]           skip_q, skip_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 tmo;

`ifdef JCAPTURE_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wdog_q;

  // Counts COMPRESS cycles; zero on the first cycle of every COMPRESS visit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_q <= '0;
    end else if (state_q == S_COMP) begin
      wdog_q <= wdog_q + TIMEOUT_W'(1);
    end else begin
      wdog_q <= '0;
    end
  end

  assign tmo = (timeout_cycles != '0) &&
               (wdog_q == timeout_cycles - TIMEOUT_W'(1));
`else
  logic unused_tmo;
  assign unused_tmo = ^timeout_cycles;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_ERROR, S_VALID: begin
          // IMAGE_VALID re-arms itself after one cycle in continuous mode.
          if (start_capture ||
              (state_q == S_VALID && continuous)) begin
            state_d = S_RESET;
            skip_d  = skip_frames;
            if (start_capture) err_d = 1'b0;
          end
        end
        S_RESET: begin
          // Let any frame already in flight finish before looking for a start.
          if (!frame_valid) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (frame_valid) begin
            if (skip_q != '0) begin
              skip_d  = skip_q - 4'd1;
              state_d = S_RESET;
            end else begin
              state_d = S_COMP;
            end
          end
        end
        S_COMP: begin
          if (encode_done) begin
            state_d = S_VALID;
            cnt_d   = cnt_q + FRAME_CNT_W'(1);
          end else if (tmo) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Decoded from registers only, so jpeg_en is already high in WAIT
  // when the first frame_valid of the target frame arrives.
  always_comb begin
    jpeg_en     = (state_q == S_COMP) ||
                  (state_q == S_WAIT && skip_q == '0);
    image_valid = (state_q == S_VALID);
    busy        = (state_q == S_RESET) ||
                  (state_q == S_WAIT) ||
                  (state_q == S_COMP);
    frame_cnt   = cnt_q;
    state       = state_q;
`ifdef JCAPTURE_TIMEOUT_EN
    timeout_err = err_q;
`else
    timeout_err = 1'b0;
`endif
  end

endmodule
